// File: rtl/iiitb_sipo_pkg.sv
// Shared types and constants for the iiitb_sipo serial-in/parallel-out receiver.
package iiitb_sipo_pkg;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    SYNC  = 2'd1,
    SHIFT = 2'd2
  } state_t;

  localparam int DEFAULT_WIDTH = 8;

  // Width of a counter that indexes 0..value-1; never narrower than one bit.
  function automatic int clog2(input int value);
    int r;
    r = 0;
    while ((1 << r) < value) r++;
    return (r < 1) ? 1 : r;
  endfunction

endpackage

// File: rtl/iiitb_sipo_if.sv
// Frame/consumer signal bundle for iiitb_sipo; the master side feeds the line and consumes words.
interface iiitb_sipo_if
  import iiitb_sipo_pkg::*;
#(
  parameter int WIDTH = DEFAULT_WIDTH
) ();

  // Handshake: a word transfers on any clk edge where valid && ready are both 1.
  // valid stays high until that transfer; data_out is stable while valid is high.
  logic             load;
  logic             data_in;
  logic             ready;
  logic [WIDTH-1:0] data_out;
  logic             valid;
  logic             busy;
  logic             framing_err;
  logic             overrun;
  state_t           dbg_state;

  modport master (
    output load, data_in, ready,
    input  data_out, valid, busy, framing_err, overrun, dbg_state
  );

  modport slave (
    input  load, data_in, ready,
    output data_out, valid, busy, framing_err, overrun, dbg_state
  );

endinterface

// File: rtl/iiitb_sipo_shreg.sv
// Assembly register: inserts one serial bit at a counter-selected position.
// Bit order follows IIITB_SIPO_MSB_FIRST_EN (defined: first bit lands in WIDTH-1).
module iiitb_sipo_shreg
  import iiitb_sipo_pkg::*;
#(
  parameter int WIDTH = DEFAULT_WIDTH,
  parameter int CW    = clog2(WIDTH)
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             clear,
  input  logic             shift_en,
  input  logic [CW-1:0]    bit_idx,
  input  logic             bit_in,
  output logic [WIDTH-1:0] word_next
);

  logic [WIDTH-1:0] word_q;
  logic [CW-1:0]    pos;

  always_comb begin
`ifdef IIITB_SIPO_MSB_FIRST_EN
    pos = CW'(WIDTH - 1) - bit_idx;
`else
    pos = bit_idx;
`endif
    word_next      = word_q;
    word_next[pos] = bit_in;
  end

  // clear wins so an abort or back-to-back start always begins from zero.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      word_q <= '0;
    end else if (clear) begin
      word_q <= '0;
    end else if (shift_en) begin
      word_q <= word_next;
    end
  end

endmodule

// File: rtl/iiitb_sipo.sv
// Serial-in/parallel-out receiver: guard bit then WIDTH data bits, buffered output with handshake.
// Optional build macro: IIITB_SIPO_MSB_FIRST_EN (MSB-first bit order).
module iiitb_sipo
  import iiitb_sipo_pkg::*;
#(
  parameter int WIDTH = DEFAULT_WIDTH
) (
  input  logic        clk,
  input  logic        rst,
  iiitb_sipo_if.slave bus
);

  localparam int CW = clog2(WIDTH);
  localparam logic [CW-1:0] LAST = CW'(WIDTH - 1);

  state_t           state_q, state_d;
  logic [CW-1:0]    cnt_q, cnt_d;
  logic             clear, shift_en, complete, set_ferr;
  logic [WIDTH-1:0] word_next;
  logic [WIDTH-1:0] data_out_q;
  logic             valid_q, ferr_q, overrun_q;

  iiitb_sipo_shreg #(.WIDTH(WIDTH), .CW(CW)) u_shreg (
    .clk       (clk),
    .rst       (rst),
    .clear     (clear),
    .shift_en  (shift_en),
    .bit_idx   (cnt_q),
    .bit_in    (bus.data_in),
    .word_next (word_next)
  );

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q <= IDLE;
      cnt_q   <= '0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
    end
  end

  always_comb begin
    state_d  = state_q;
    cnt_d    = cnt_q;
    clear    = 1'b0;
    shift_en = 1'b0;
    complete = 1'b0;
    set_ferr = 1'b0;
    case (state_q)
      IDLE: begin
        if (bus.load) begin
          state_d = SYNC;
          cnt_d   = '0;
          clear   = 1'b1;
        end
      end
      SYNC: begin
        cnt_d = '0;
        if (bus.load) begin
          clear = 1'b1;
        end else begin
          set_ferr = bus.data_in;
          state_d  = SHIFT;
        end
      end
      SHIFT: begin
        if (cnt_q == LAST) begin
          // Last bit completes the word even if a new load arrives on this edge.
          shift_en = 1'b1;
          complete = 1'b1;
          cnt_d    = '0;
          clear    = bus.load;
          state_d  = bus.load ? SYNC : IDLE;
        end else if (bus.load) begin
          state_d = SYNC;
          cnt_d   = '0;
          clear   = 1'b1;
        end else begin
          shift_en = 1'b1;
          cnt_d    = cnt_q + CW'(1);
        end
      end
      default: begin
        state_d = IDLE;
        cnt_d   = '0;
      end
    endcase
  end

  // A completing word is accepted only if the buffer is empty or being drained this edge.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      data_out_q <= '0;
      valid_q    <= 1'b0;
      ferr_q     <= 1'b0;
      overrun_q  <= 1'b0;
    end else begin
      if (set_ferr) ferr_q <= 1'b1;
      if (complete) begin
        if (!valid_q || bus.ready) begin
          data_out_q <= word_next;
          valid_q    <= 1'b1;
        end else begin
          overrun_q <= 1'b1;
        end
      end else if (valid_q && bus.ready) begin
        valid_q <= 1'b0;
      end
    end
  end

  assign bus.data_out    = data_out_q;
  assign bus.valid       = valid_q;
  assign bus.framing_err = ferr_q;
  assign bus.overrun     = overrun_q;
  assign bus.busy        = (state_q != IDLE);
  assign bus.dbg_state   = state_q;

endmodule

// File: tb/tb_iiitb_sipo.sv
// Directed bench for iiitb_sipo: frames, handshake, back-to-back, overrun, abort, errors, reset.
module tb_iiitb_sipo;
  import iiitb_sipo_pkg::*;

  localparam int W = 8;

  logic clk;
  logic rst;
  int   n_tests;
  int   n_fail;

  iiitb_sipo_if #(.WIDTH(W)) bus ();

  iiitb_sipo #(.WIDTH(W)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  // clock / reset
  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s got=0x%0h exp=0x%0h", tag, got, exp);
    end
  endtask

  // One clock edge; inputs change and outputs are sampled 1ns after it.
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic drive(input logic ld, input logic din);
    bus.load    = ld;
    bus.data_in = din;
    tick();
  endtask

  // Optional load edge (E0), guard edge, then W data bits in the build's bit order.
  task automatic send_frame(input logic [W-1:0] word, input logic guard,
                            input logic start_load, input logic load_on_last);
    logic b;
    if (start_load) drive(1'b1, 1'b0);
    drive(1'b0, guard);
    for (int i = 0; i < W; i++) begin
`ifdef IIITB_SIPO_MSB_FIRST_EN
      b = word[W-1-i];
`else
      b = word[i];
`endif
      drive((i == W - 1) ? load_on_last : 1'b0, b);
    end
    bus.load = 1'b0;
  endtask

  initial begin
    n_tests     = 0;
    n_fail      = 0;
    rst         = 1'b0;
    bus.load    = 1'b0;
    bus.data_in = 1'b0;
    bus.ready   = 1'b0;
    tick();
    tick();
    check("rst_data_out", 32'(bus.data_out), 32'h0);
    check("rst_valid", 32'(bus.valid), 32'h0);
    check("rst_busy", 32'(bus.busy), 32'h0);
    check("rst_ferr", 32'(bus.framing_err), 32'h0);
    check("rst_overrun", 32'(bus.overrun), 32'h0);
    rst = 1'b1;
    tick();

    // Basic frame with per-edge busy/valid tracking
    drive(1'b1, 1'b0);                       // E0
    check("basic_busy_e0", 32'(bus.busy), 32'h1);
    check("basic_state_e0", 32'(bus.dbg_state), 32'(SYNC));
    drive(1'b0, 1'b0);                       // E1 guard
    for (int i = 0; i < W; i++) begin
      logic [W-1:0] w;
      w = 8'hA5;
`ifdef IIITB_SIPO_MSB_FIRST_EN
      drive(1'b0, w[W-1-i]);
`else
      drive(1'b0, w[i]);
`endif
      if (i == W - 2) begin                  // after E8
        check("basic_valid_e8", 32'(bus.valid), 32'h0);
        check("basic_busy_e8", 32'(bus.busy), 32'h1);
      end
    end
    check("basic_data", 32'(bus.data_out), 32'hA5);
    check("basic_valid", 32'(bus.valid), 32'h1);
    check("basic_busy_e9", 32'(bus.busy), 32'h0);

    // Handshake: hold off, then a single ready cycle drains the word
    for (int i = 0; i < 5; i++) begin
      tick();
      check("hold_data", 32'(bus.data_out), 32'hA5);
      check("hold_valid", 32'(bus.valid), 32'h1);
    end
    bus.ready = 1'b1;
    tick();
    bus.ready = 1'b0;
    check("drain_valid", 32'(bus.valid), 32'h0);
    check("drain_data", 32'(bus.data_out), 32'hA5);

    // Back-to-back with ready tied high; second load shares E9
    bus.ready = 1'b1;
    send_frame(8'h3C, 1'b0, 1'b1, 1'b1);
    check("b2b_first_data", 32'(bus.data_out), 32'h3C);
    check("b2b_first_valid", 32'(bus.valid), 32'h1);
    check("b2b_busy", 32'(bus.busy), 32'h1);
    send_frame(8'hC3, 1'b0, 1'b0, 1'b0);
    check("b2b_second_data", 32'(bus.data_out), 32'hC3);
    check("b2b_second_valid", 32'(bus.valid), 32'h1);
    check("b2b_overrun", 32'(bus.overrun), 32'h0);
    tick();
    bus.ready = 1'b0;
    check("b2b_drained", 32'(bus.valid), 32'h0);

    // Overrun: second word arrives while the first is unconsumed
    send_frame(8'h11, 1'b0, 1'b1, 1'b0);
    send_frame(8'h22, 1'b0, 1'b1, 1'b0);
    check("ovr_data", 32'(bus.data_out), 32'h11);
    check("ovr_flag", 32'(bus.overrun), 32'h1);
    check("ovr_valid", 32'(bus.valid), 32'h1);
    bus.ready = 1'b1;
    tick();
    bus.ready = 1'b0;

    // Abort: partial frame E0..E4, reload at E5, new word completes at E14
    drive(1'b1, 1'b0);                       // E0
    drive(1'b0, 1'b0);                       // E1 guard
    drive(1'b0, 1'b1);                       // E2
    drive(1'b0, 1'b1);                       // E3
    drive(1'b0, 1'b1);                       // E4
    send_frame(8'h5A, 1'b0, 1'b1, 1'b0);     // load at E5, completes at E14
    check("abort_data", 32'(bus.data_out), 32'h5A);
    check("abort_valid", 32'(bus.valid), 32'h1);
    bus.ready = 1'b1;
    tick();
    bus.ready = 1'b0;

    // Framing error still delivers the word
    send_frame(8'h96, 1'b1, 1'b1, 1'b0);
    check("ferr_flag", 32'(bus.framing_err), 32'h1);
    check("ferr_data", 32'(bus.data_out), 32'h96);
    check("ferr_valid", 32'(bus.valid), 32'h1);

    // Asynchronous reset mid-frame, then an idle line must not capture
    drive(1'b1, 1'b0);                       // E0
    drive(1'b0, 1'b0);                       // E1
    drive(1'b0, 1'b1);                       // E2
    drive(1'b0, 1'b0);                       // E3
    rst = 1'b0;
    #1;
    check("arst_data", 32'(bus.data_out), 32'h0);
    check("arst_valid", 32'(bus.valid), 32'h0);
    check("arst_busy", 32'(bus.busy), 32'h0);
    check("arst_ferr", 32'(bus.framing_err), 32'h0);
    check("arst_overrun", 32'(bus.overrun), 32'h0);
    tick();
    rst = 1'b1;
    for (int i = 0; i < W + 2; i++) drive(1'b0, 1'(i & 1));
    check("post_rst_valid", 32'(bus.valid), 32'h0);
    check("post_rst_busy", 32'(bus.busy), 32'h0);

    // Serial 1,0,1,0,0,1,0,1 gives 0xA5 in either bit order
    drive(1'b1, 1'b0);
    drive(1'b0, 1'b0);
    begin
      logic [7:0] ser;
      ser = 8'b1010_0101;
      for (int i = 0; i < W; i++) drive(1'b0, ser[7-i]);
    end
    check("order_data", 32'(bus.data_out), 32'hA5);
    check("order_valid", 32'(bus.valid), 32'h1);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL timeout got=running exp=finished");
    $fatal(1, "timeout");
  end

endmodule
